// File: rtl/mips_isa_pkg.sv
// MIPS ISA constants and the mnemonic-to-word encoder that the loader uses.
// The opcode/funct values match the ones the control unit decodes.
package mips_isa_pkg;

  typedef enum logic [4:0] {
    M_ADD   = 5'd0,  M_ADDU  = 5'd1,  M_AND   = 5'd2,  M_JR    = 5'd3,
    M_NOR   = 5'd4,  M_OR    = 5'd5,  M_SLT   = 5'd6,  M_SLTU  = 5'd7,
    M_SLL   = 5'd8,  M_SRL   = 5'd9,  M_SUB   = 5'd10, M_SUBU  = 5'd11,
    M_SRA   = 5'd12, M_J     = 5'd13, M_JAL   = 5'd14, M_ADDI  = 5'd15,
    M_ADDIU = 5'd16, M_ANDI  = 5'd17, M_BEQ   = 5'd18, M_BNE   = 5'd19,
    M_LL    = 5'd20, M_LUI   = 5'd21, M_LW    = 5'd22, M_ORI   = 5'd23,
    M_SLTI  = 5'd24, M_SLTIU = 5'd25, M_SW    = 5'd26, M_ILLEGAL = 5'h1F
  } mnem_e;

  localparam logic [5:0] FN_ADD  = 6'b100000, FN_ADDU = 6'b100001,
                         FN_AND  = 6'b100100, FN_JR   = 6'b001000,
                         FN_NOR  = 6'b100111, FN_OR   = 6'b100101,
                         FN_SLT  = 6'b101010, FN_SLTU = 6'b101011,
                         FN_SLL  = 6'b000000, FN_SRL  = 6'b000010,
                         FN_SUB  = 6'b100010, FN_SUBU = 6'b100011,
                         FN_SRA  = 6'b000011;

  localparam logic [5:0] OP_RTYPE = 6'b000000,
                         OP_J     = 6'b000010, OP_JAL   = 6'b000011,
                         OP_ADDI  = 6'b001000, OP_ADDIU = 6'b001001,
                         OP_ANDI  = 6'b001100, OP_BEQ   = 6'b000100,
                         OP_BNE   = 6'b000101, OP_LL    = 6'b110000,
                         OP_LUI   = 6'b001111, OP_LW    = 6'b100011,
                         OP_ORI   = 6'b001101, OP_SLTI  = 6'b001010,
                         OP_SLTIU = 6'b001011, OP_SW    = 6'b101011;

  typedef enum logic [1:0] {FMT_R, FMT_I, FMT_J, FMT_NONE} fmt_e;

  typedef struct packed {
    logic        legal;
    logic [31:0] word;
  } enc_t;

  function automatic enc_t encode(input logic [4:0] mnem,
                                  input logic [4:0] rs, input logic [4:0] rt,
                                  input logic [4:0] rd, input logic [4:0] shamt,
                                  input logic [15:0] imm, input logic [25:0] target);
    fmt_e       fmt;
    logic [5:0] code;
    logic [4:0] rs_e, rt_e, rd_e, sh_e;
    enc_t       r;
    fmt  = FMT_NONE;
    code = 6'b0;
    rs_e = rs; rt_e = rt; rd_e = rd; sh_e = shamt;
    case (mnem_e'(mnem))
      M_ADD:   begin fmt = FMT_R; code = FN_ADD;  end
      M_ADDU:  begin fmt = FMT_R; code = FN_ADDU; end
      M_AND:   begin fmt = FMT_R; code = FN_AND;  end
      M_JR:    begin fmt = FMT_R; code = FN_JR; rt_e = '0; rd_e = '0; sh_e = '0; end
      M_NOR:   begin fmt = FMT_R; code = FN_NOR;  end
      M_OR:    begin fmt = FMT_R; code = FN_OR;   end
      M_SLT:   begin fmt = FMT_R; code = FN_SLT;  end
      M_SLTU:  begin fmt = FMT_R; code = FN_SLTU; end
      M_SLL:   begin fmt = FMT_R; code = FN_SLL; rs_e = '0; end
      M_SRL:   begin fmt = FMT_R; code = FN_SRL; rs_e = '0; end
      M_SRA:   begin fmt = FMT_R; code = FN_SRA; rs_e = '0; end
      M_SUB:   begin fmt = FMT_R; code = FN_SUB;  end
      M_SUBU:  begin fmt = FMT_R; code = FN_SUBU; end
      M_J:     begin fmt = FMT_J; code = OP_J;    end
      M_JAL:   begin fmt = FMT_J; code = OP_JAL;  end
      M_ADDI:  begin fmt = FMT_I; code = OP_ADDI; end
      M_ADDIU: begin fmt = FMT_I; code = OP_ADDIU; end
      M_ANDI:  begin fmt = FMT_I; code = OP_ANDI; end
      M_BEQ:   begin fmt = FMT_I; code = OP_BEQ;  end
      M_BNE:   begin fmt = FMT_I; code = OP_BNE;  end
      M_LL:    begin fmt = FMT_I; code = OP_LL;   end
      M_LUI:   begin fmt = FMT_I; code = OP_LUI; rs_e = '0; end
      M_LW:    begin fmt = FMT_I; code = OP_LW;   end
      M_ORI:   begin fmt = FMT_I; code = OP_ORI;  end
      M_SLTI:  begin fmt = FMT_I; code = OP_SLTI; end
      M_SLTIU: begin fmt = FMT_I; code = OP_SLTIU; end
      M_SW:    begin fmt = FMT_I; code = OP_SW;   end
      default: fmt = FMT_NONE;
    endcase
    case (fmt)
      FMT_R:   r.word = {OP_RTYPE, rs_e, rt_e, rd_e, sh_e, code};
      FMT_I:   r.word = {code, rs_e, rt_e, imm};
      FMT_J:   r.word = {code, target};
      default: r.word = 32'b0;
    endcase
    r.legal = (fmt != FMT_NONE);
    return r;
  endfunction

endpackage

// File: rtl/instr_encode_loader_if.sv
// Request/write/status bundle between the boot harness (master) and the loader (slave).
interface instr_encode_loader_if #(parameter int ADDR_W = 10);
  logic              load_start;
  logic [ADDR_W-1:0] base_addr;
  logic              load_end;
  logic              op_valid;
  logic              op_ready;
  logic [4:0]        op_mnem, op_rs, op_rt, op_rd, op_shamt;
  logic [15:0]       op_imm;
  logic [25:0]       op_target;
  logic              imem_we;
  logic              imem_ready;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              busy, done;
  logic [ADDR_W:0]   words_written;
  logic              err_illegal, err_overflow;

  modport master (
    output load_start, base_addr, load_end, op_valid, op_mnem, op_rs, op_rt,
           op_rd, op_shamt, op_imm, op_target, imem_ready,
    input  op_ready, imem_we, imem_addr, imem_wdata, busy, done,
           words_written, err_illegal, err_overflow
  );

  modport slave (
    input  load_start, base_addr, load_end, op_valid, op_mnem, op_rs, op_rt,
           op_rd, op_shamt, op_imm, op_target, imem_ready,
    output op_ready, imem_we, imem_addr, imem_wdata, busy, done,
           words_written, err_illegal, err_overflow
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with count-based full/empty and a synchronous clear.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr, rptr;
  logic [PW:0]      cnt;
  logic             push_ok, pop_ok;

  assign full    = (cnt == (PW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else if (clr) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: pointers/count gate every read.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= din;
  end
endmodule

// File: rtl/instr_encode_loader.sv
// Encodes mnemonic requests into MIPS words and streams them into instruction
// memory from a latched base address, stopping at the top of the address space.
module instr_encode_loader
  import mips_isa_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  instr_encode_loader_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DONE} state_e;

  state_e            state;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W:0]   wcnt;
  logic              exhausted, err_ill, busy_q, done_q;
  logic              full, empty, op_fire, wr_fire, we;
  logic [31:0]       head;
  logic [ADDR_W-1:0] addr;
  enc_t              enc;

  assign enc = encode(bus.op_mnem, bus.op_rs, bus.op_rt, bus.op_rd,
                      bus.op_shamt, bus.op_imm, bus.op_target);

  assign op_fire = bus.op_valid && bus.op_ready;
  // Once the last word address is written nothing else may leave the FIFO.
  assign we      = !empty && !exhausted && (state == S_LOAD || state == S_FLUSH);
  assign wr_fire = we && bus.imem_ready;
  assign addr    = base + wcnt[ADDR_W-1:0];

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state == S_DONE),
    .push  (op_fire && enc.legal),
    .din   (enc.word),
    .pop   (wr_fire),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  assign bus.op_ready      = (state == S_LOAD) && !full && !exhausted;
  assign bus.imem_we       = we;
  assign bus.imem_addr     = addr;
  assign bus.imem_wdata    = we ? head : 32'b0;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.words_written = wcnt;
  assign bus.err_illegal   = err_ill;
  assign bus.err_overflow  = exhausted;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      base      <= '0;
      wcnt      <= '0;
      exhausted <= 1'b0;
      err_ill   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: if (bus.load_start) begin
          state     <= S_LOAD;
          busy_q    <= 1'b1;
          base      <= bus.base_addr;
          wcnt      <= '0;
          exhausted <= 1'b0;
          err_ill   <= 1'b0;
        end
        S_LOAD: if (bus.load_end) state <= S_FLUSH;
        // Leftover words after exhaustion are dropped by the clear in DONE.
        S_FLUSH: if (empty || exhausted) begin
          state  <= S_DONE;
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
      if (wr_fire) begin
        wcnt <= wcnt + 1'b1;
        if (addr == '1) exhausted <= 1'b1;
      end
      if (op_fire && !enc.legal) err_ill <= 1'b1;
    end
  end
endmodule

// File: tb/tb_instr_encode_loader.sv
// Directed bench: expected writes are queued on op acceptance, a negedge
// monitor pops and compares every completed memory write.
module tb_instr_encode_loader;
  import mips_isa_pkg::*;
  localparam int ADDR_W = 10;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_encode_loader_if #(.ADDR_W(ADDR_W)) bus ();
  instr_encode_loader #(.ADDR_W(ADDR_W), .DEPTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  exp_t              q[$];
  int                vecs = 0;
  int                errs = 0;
  logic [ADDR_W-1:0] nxt;
  logic              tb_exh;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.imem_we === 1'b1 && bus.imem_ready === 1'b1) begin
      exp_t e;
      if (q.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL unexpected_write: addr %h data %h, none expected",
                 bus.imem_addr, bus.imem_wdata);
      end else begin
        e = q.pop_front();
        chk("wr_addr", 32'(bus.imem_addr), 32'(e.addr));
        chk("wr_data", bus.imem_wdata, e.data);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [4:0] m, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sh,
                        input logic [15:0] imm, input logic [25:0] tg);
    bus.op_mnem = m; bus.op_rs = rs; bus.op_rt = rt; bus.op_rd = rd;
    bus.op_shamt = sh; bus.op_imm = imm; bus.op_target = tg;
    bus.op_valid = 1'b1;
  endtask

  task automatic send_op(input logic [4:0] m, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [4:0] sh,
                         input logic [15:0] imm, input logic [25:0] tg,
                         input logic [31:0] w, input logic expect_wr);
    logic acc;
    int   n;
    exp_t e;
    acc = 1'b0;
    n   = 0;
    set_op(m, rs, rt, rd, sh, imm, tg);
    while (!acc && n < 40) begin
      @(negedge clk);
      acc = bus.op_ready;
      @(posedge clk);
      #1;
      n++;
    end
    bus.op_valid = 1'b0;
    chk("op_accept", 32'(acc), 32'd1);
    if (acc && expect_wr && !tb_exh) begin
      e.addr = nxt;
      e.data = w;
      q.push_back(e);
      if (nxt == '1) tb_exh = 1'b1;
      nxt = nxt + 1'b1;
    end
  endtask

  task automatic start(input logic [ADDR_W-1:0] b);
    bus.base_addr  = b;
    bus.load_start = 1'b1;
    tick(1);
    bus.load_start = 1'b0;
    nxt    = b;
    tb_exh = 1'b0;
  endtask

  task automatic end_load();
    bus.load_end = 1'b1;
    tick(1);
    bus.load_end = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain", 32'(q.size()), 32'd0);
  endtask

  task automatic wait_done(input int exp_words);
    logic seen;
    logic [31:0] wc;
    int n;
    seen = 1'b0;
    wc   = '1;
    n    = 0;
    while (!seen && n < 60) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        wc   = 32'(bus.words_written);
      end
      n++;
    end
    chk("done_pulse", 32'(seen), 32'd1);
    chk("done_words", wc, 32'(exp_words));
    @(negedge clk);
    chk("done_width", 32'(bus.done), 32'd0);
    tick(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.load_start = 0; bus.base_addr = '0; bus.load_end = 0; bus.op_valid = 0;
    bus.op_mnem = '0; bus.op_rs = '0; bus.op_rt = '0; bus.op_rd = '0;
    bus.op_shamt = '0; bus.op_imm = '0; bus.op_target = '0; bus.imem_ready = 1'b1;
    nxt = '0; tb_exh = 1'b0;

    #12;
    chk("rst_op_ready", 32'(bus.op_ready), 32'd0);
    chk("rst_imem_we", 32'(bus.imem_we), 32'd0);
    chk("rst_status", {27'b0, bus.busy, bus.done, bus.err_illegal, bus.err_overflow, 1'b0}, 32'd0);
    chk("rst_words", 32'(bus.words_written), 32'd0);
    chk("rst_addr", 32'(bus.imem_addr), 32'd0);
    chk("rst_wdata", bus.imem_wdata, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    tick(2);

    // Session 1: basic encodings
    start(10'h010);
    chk("busy_load", 32'(bus.busy), 32'd1);
    send_op(M_ADD,  5'd1,  5'd2, 5'd3, 5'd0, 16'h0,    26'h0,  32'h00221820, 1'b1);
    send_op(M_ADDI, 5'd0,  5'd5, 5'd0, 5'd0, 16'h0010, 26'h0,  32'h20050010, 1'b1);
    send_op(M_LUI,  5'd7,  5'd8, 5'd0, 5'd0, 16'h1234, 26'h0,  32'h3C081234, 1'b1);
    send_op(M_SW,   5'd29, 5'd2, 5'd0, 5'd0, 16'h0004, 26'h0,  32'hAFA20004, 1'b1);
    send_op(M_J,    5'd0,  5'd0, 5'd0, 5'd0, 16'h0,    26'h10, 32'h08000010, 1'b1);
    drain();
    chk("err_illegal_clear", 32'(bus.err_illegal), 32'd0);

    // Illegal mnemonic mid-stream
    send_op(5'h1F, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 32'h0, 1'b0);
    tick(2);
    chk("err_illegal_set", 32'(bus.err_illegal), 32'd1);
    chk("words_after_illegal", 32'(bus.words_written), 32'd5);
    chk("no_write_illegal", 32'(bus.imem_we), 32'd0);
    send_op(M_ORI, 5'd1, 5'd2, 5'd0, 5'd0, 16'hABCD, 26'h0, 32'h3422ABCD, 1'b1);
    drain();

    // Backpressure: 4 fill the FIFO, the 5th stalls
    bus.imem_ready = 1'b0;
    send_op(M_ADDU, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 32'h00221821, 1'b1);
    send_op(M_OR,   5'd4, 5'd5, 5'd6, 5'd0, 16'h0, 26'h0, 32'h00853025, 1'b1);
    send_op(M_SLL,  5'd9, 5'd2, 5'd3, 5'd4, 16'h0, 26'h0, 32'h00021900, 1'b1);
    send_op(M_JR,   5'd31, 5'd1, 5'd7, 5'd3, 16'h0, 26'h0, 32'h03E00008, 1'b1);
    set_op(M_BEQ, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFF, 26'h0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_op_ready", 32'(bus.op_ready), 32'd0);
      chk("hold_we", 32'(bus.imem_we), 32'd1);
      chk("hold_addr", 32'(bus.imem_addr), 32'h016);
      chk("hold_data", bus.imem_wdata, 32'h00221821);
    end
    tick(1);
    bus.imem_ready = 1'b1;
    send_op(M_BEQ, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFF, 26'h0, 32'h1022FFFF, 1'b1);
    send_op(M_JAL, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h3FFFFFF, 32'h0FFFFFFF, 1'b1);
    drain();
    end_load();
    wait_done(12);
    chk("busy_idle", 32'(bus.busy), 32'd0);

    // Session 2: address-space exhaustion
    start(10'h3FE);
    chk("err_illegal_cleared", 32'(bus.err_illegal), 32'd0);
    send_op(M_ADD,  5'd1, 5'd2, 5'd3, 5'd0, 16'h0,    26'h0, 32'h00221820, 1'b1);
    send_op(M_ADDI, 5'd0, 5'd5, 5'd0, 5'd0, 16'h0010, 26'h0, 32'h20050010, 1'b1);
    tick(4);
    chk("overflow_set", 32'(bus.err_overflow), 32'd1);
    chk("overflow_words", 32'(bus.words_written), 32'd2);
    set_op(M_SW, 5'd29, 5'd2, 5'd0, 5'd0, 16'h4, 26'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("overflow_op_ready", 32'(bus.op_ready), 32'd0);
    end
    tick(1);
    bus.op_valid = 1'b0;
    end_load();
    wait_done(2);
    chk("overflow_queue", 32'(q.size()), 32'd0);

    // Session 3: reset during FLUSH with words queued
    start(10'h100);
    bus.imem_ready = 1'b0;
    send_op(M_ADD, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 32'h0, 1'b0);
    send_op(M_OR,  5'd4, 5'd5, 5'd6, 5'd0, 16'h0, 26'h0, 32'h0, 1'b0);
    end_load();
    tick(1);
    chk("flush_busy", 32'(bus.busy), 32'd1);
    chk("flush_we", 32'(bus.imem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_we", 32'(bus.imem_we), 32'd0);
    chk("midrst_wdata", bus.imem_wdata, 32'd0);
    chk("midrst_addr", 32'(bus.imem_addr), 32'd0);
    chk("midrst_status", {28'b0, bus.busy, bus.done, bus.op_ready, bus.err_overflow}, 32'd0);
    chk("midrst_words", 32'(bus.words_written), 32'd0);
    tick(1);
    rst_n = 1'b1;
    bus.imem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_done", 32'(bus.done), 32'd0);
      chk("post_rst_we", 32'(bus.imem_we), 32'd0);
    end
    chk("final_queue", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
